// File: rtl/shift_tick_gen.sv
// rtl/shift_tick_gen.sv - step pulse generator with selectable period and debounced direction toggle
module shift_tick_gen #(
    parameter int     NB_CNT     = 32,
    parameter longint PERIOD0    = 64'd1 << 23,
    parameter longint PERIOD1    = 64'd1 << 24,
    parameter longint PERIOD2    = 64'd1 << 25,
    parameter longint PERIOD3    = 64'd1 << 26,
    parameter int     DEB_CYCLES = 1000000,
    parameter int     NB_DEB     = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_sel,
    input  logic       i_btn_dir,
    output logic       o_valid,
    output logic       o_dir
);

    // Limits are stored minus one so a period of 2**NB_CNT still fits the counter width.
    localparam logic [NB_CNT-1:0] LIM0_M1  = NB_CNT'(PERIOD0 - 64'd1);
    localparam logic [NB_CNT-1:0] LIM1_M1  = NB_CNT'(PERIOD1 - 64'd1);
    localparam logic [NB_CNT-1:0] LIM2_M1  = NB_CNT'(PERIOD2 - 64'd1);
    localparam logic [NB_CNT-1:0] LIM3_M1  = NB_CNT'(PERIOD3 - 64'd1);
    localparam logic [NB_DEB-1:0] DEB_LAST = NB_DEB'(DEB_CYCLES - 1);

    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic [NB_CNT-1:0] lim_m1;
    logic              valid_q, valid_d;
    logic              s1_q, s2_q;
    logic              stable_q, stable_d;
    logic [NB_DEB-1:0] deb_q, deb_d;
    logic              dir_q, dir_d;

    always_comb begin
        lim_m1 = LIM0_M1;
        case (i_sel)
            2'd0:    lim_m1 = LIM0_M1;
            2'd1:    lim_m1 = LIM1_M1;
            2'd2:    lim_m1 = LIM2_M1;
            default: lim_m1 = LIM3_M1;
        endcase
    end

    // >= rather than == so a shorter period selected mid-count wraps at once.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (i_enable) begin
            if (cnt_q >= lim_m1) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + NB_CNT'(1);
            end
        end
    end

    always_comb begin
        stable_d = stable_q;
        deb_d    = deb_q;
        dir_d    = dir_q;
        if (s2_q == stable_q) begin
            deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
            stable_d = s2_q;
            deb_d    = '0;
            if (s2_q) begin
                dir_d = ~dir_q;
            end
        end else begin
            deb_d = deb_q + NB_DEB'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            deb_q    <= '0;
            dir_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            s1_q     <= i_btn_dir;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            deb_q    <= deb_d;
            dir_q    <= dir_d;
        end
    end

    assign o_valid = valid_q;
    assign o_dir   = dir_q;

endmodule

// File: tb/tb_shift_tick_gen.sv
// tb/tb_shift_tick_gen.sv - self-checking bench for shift_tick_gen
module tb_shift_tick_gen;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_sel;
    logic       i_btn_dir;
    logic       o_valid;
    logic       o_dir;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic       btn;
        logic       exp_valid;
        logic       exp_dir;
    } vec_t;

    vec_t       tbl[12];
    logic [1:0] exp_q[$];
    logic       prev_valid = 1'b0;

    shift_tick_gen #(
        .NB_CNT    (32),
        .PERIOD0   (4),
        .PERIOD1   (8),
        .PERIOD2   (16),
        .PERIOD3   (32),
        .DEB_CYCLES(5),
        .NB_DEB    (3)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_sel    (i_sel),
        .i_btn_dir(i_btn_dir),
        .o_valid  (o_valid),
        .o_dir    (o_dir)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; applies inputs for one rising edge and checks just after it.
    task automatic drive(input logic en, input logic [1:0] sel, input logic btn,
                         input logic ev, input logic ed, input string name);
        logic [1:0] e;
        i_enable  = en;
        i_sel     = sel;
        i_btn_dir = btn;
        exp_q.push_back({ev, ed});
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_valid"}, o_valid, e[1]);
            check({name, "_dir"}, o_dir, e[0]);
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset   = 1'b1;
        i_enable  = 1'b0;
        i_sel     = 2'd0;
        i_btn_dir = 1'b0;
        @(negedge i_clk);
        check("reset_valid", o_valid, 1'b0);
        check("reset_dir", o_dir, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (!i_reset && prev_valid && o_valid) begin
            n_miss++;
            $display("FAIL valid_width: got two consecutive high cycles at %0t", $time);
        end
        prev_valid = i_reset ? 1'b0 : o_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{en: 1'b1, sel: 2'd0, btn: 1'b0,
                       exp_valid: ((i % 4) == 3), exp_dir: 1'b0};
        end

        // Basic period 4 from reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].sel, tbl[i].btn, tbl[i].exp_valid, tbl[i].exp_dir, "period4");
        end

        // Enable gating at period 8: 5 enabled, 10 disabled, then 3 more reach the pulse
        do_reset();
        for (int i = 0; i < 5; i++)  drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, "gate_pre");
        for (int i = 0; i < 10; i++) drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, "gate_off");
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, "gate_re1");
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, "gate_re2");
        drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, "gate_pulse");
        for (int i = 0; i < 7; i++)  drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, "gate_gap");
        drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, "gate_pulse2");

        // Select change 32 -> 4 with count already at 20
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "sel32");
        for (int i = 0; i < 9; i++)  drive(1'b1, 2'd0, 1'b0, ((i % 4) == 0), 1'b0, "seldown");

        // Debounce reject / accept
        do_reset();
        for (int i = 0; i < 3; i++)  drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "bounce_a");
        for (int i = 0; i < 4; i++)  drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "bounce_lo");
        for (int i = 0; i < 3; i++)  drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "bounce_b");
        for (int i = 0; i < 8; i++)  drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "bounce_idle");
        for (int i = 0; i < 6; i++)  drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "press_wait");
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, "press_toggle");
        for (int i = 0; i < 8; i++)  drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, "press_hold");
        for (int i = 0; i < 10; i++) drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, "release");
        for (int i = 0; i < 6; i++)  drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, "press2_wait");
        for (int i = 0; i < 4; i++)  drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "press2_toggle");

        // Reset mid-count (cnt=3) and mid-debounce (deb_cnt=3)
        do_reset();
        for (int i = 0; i < 2; i++) drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "mid_hold");
        for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, "mid_count");
        i_reset = 1'b1;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_dir", o_dir, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'd0, 1'b1, ((i % 4) == 0), (i >= 7), "after_rst");
        end

        // Outputs high, then reset drops them without waiting for a clock
        i_reset = 1'b1;
        #1;
        check("async_valid", o_valid, 1'b0);
        check("async_dir", o_dir, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "post_async");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
